uart_img_loader: RTL

- Consumes the byte stream produced by the UART receiver and assembles one binarized input image for the BNN core.
- Frame format: sync byte, then IMG_BYTES payload bytes, then one XOR checksum byte.
- On a good checksum it presents the image to the BNN core over a valid/ready handshake.
- While an image is held and not yet consumed, it drives host flow control (rts) low.

---
 rtl/bnn_uart_pkg.sv | 14 +
 rtl/uart_img_loader_if.sv | 13 +
 rtl/uart_byte_timer.sv | 30 +++
 rtl/uart_img_loader.sv | 113 +++++++++++
 4 files changed

// File: rtl/bnn_uart_pkg.sv
// rtl/bnn_uart_pkg.sv - shared types and constants for the UART image loader
package bnn_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    HOLD
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         IMG_BITS      = 100;

endpackage

// File: rtl/uart_img_loader_if.sv
// rtl/uart_img_loader_if.sv - image handshake between loader and BNN core
interface uart_img_loader_if #(
  parameter int IMG_BYTES = 13
);

  logic [IMG_BYTES*8-1:0] img_bits;
  logic                   img_valid;
  logic                   img_ready;

  modport master (output img_bits, output img_valid, input img_ready);
  modport slave  (input img_bits, input img_valid, output img_ready);

endinterface

// File: rtl/uart_byte_timer.sv
// rtl/uart_byte_timer.sv - inter-byte gap counter with terminal-count flag
module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic baud_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;

  // Saturates at the terminal count; the loader leaves the frame on that cycle anyway.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (en && (timer != LAST)) begin
      timer <= timer + 1'b1;
    end
  end

  assign expired = (timer == LAST);

endmodule

// File: rtl/uart_img_loader.sv
// rtl/uart_img_loader.sv - assembles a checksummed UART frame into one BNN input image
module uart_img_loader
  import bnn_uart_pkg::*;
#(
  parameter int         IMG_BYTES      = 13,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 200
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  uart_img_loader_if.master    img,
  output logic                 rts,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int IDX_W = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_BYTES - 1);

  loader_state_t          state;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             csum;
  logic [IMG_BYTES*8-1:0] img_bits_q;
  logic                   img_valid_q;
  logic                   in_frame;
  logic                   tmr_clr;
  logic                   tmr_en;
  logic                   tmr_expired;

  assign in_frame = (state == PAYLOAD) || (state == CHECK);
  assign tmr_clr  = !in_frame || rx_valid;
  assign tmr_en   = in_frame && !rx_valid;

  uart_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .baud_clk(baud_clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      csum        <= '0;
      img_bits_q  <= '0;
      img_valid_q <= 1'b0;
      rts         <= 1'b1;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= PAYLOAD;
            idx   <= '0;
            csum  <= '0;
          end
        end
        PAYLOAD: begin
          // A sync value here is payload; only the byte count ends this phase.
          if (rx_valid) begin
            for (int k = 0; k < IMG_BYTES; k++) begin
              if (idx == IDX_W'(k)) img_bits_q[8*k +: 8] <= rx_data;
            end
            csum <= csum ^ rx_data;
            if (idx == LAST_IDX) state <= CHECK;
            else                 idx   <= idx + 1'b1;
          end else if (tmr_expired) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              state       <= HOLD;
              img_valid_q <= 1'b1;
              rts         <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (tmr_expired) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        HOLD: begin
          // Bytes here are dropped unexamined, even when the core accepts in the same cycle.
          overrun <= rx_valid;
          if (img.img_ready) begin
            img_valid_q <= 1'b0;
            rts         <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign img.img_bits  = img_bits_q;
  assign img.img_valid = img_valid_q;

endmodule
